// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared cpu types for the instruction cache
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 26;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    LOOKUP = 1'b0,
    FILL   = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-block instruction cache with fill FSM
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t     state_q;
  logic [29:0]       miss_addr_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic              hit;
  logic              unused_byteoff;

  assign req_idx        = imemaddr[IDX_W+1:2];
  assign req_tag        = imemaddr[31:IDX_W+2];
  assign miss_idx       = miss_addr_q[IDX_W-1:0];
  assign miss_tag       = miss_addr_q[29:IDX_W];
  assign unused_byteoff = ^imemaddr[1:0];

  // Hits are only reported in LOOKUP, so a fill never bypasses iload to imemload.
  assign hit = (state_q == LOOKUP) && imemREN && valid_q[req_idx]
             && (tag_q[req_idx] == req_tag);

  assign ihit     = hit;
  assign imemload = hit ? data_q[req_idx] : 32'h0;
  assign iREN     = (state_q == FILL);
  assign iaddr    = (state_q == FILL) ? {miss_addr_q, 2'b00} : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= LOOKUP;
      miss_addr_q <= '0;
      valid_q     <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (iflush) begin
      // Flush beats a completing fill: the frame must stay invalid.
      valid_q <= '0;
      state_q <= LOOKUP;
    end else begin
      case (state_q)
        LOOKUP: begin
          if (imemREN && !hit) begin
            miss_addr_q <= imemaddr[31:2];
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (!iwait) begin
            valid_q[miss_idx] <= 1'b1;
            tag_q[miss_idx]   <= miss_tag;
            data_q[miss_idx]  <= iload;
            state_q           <= LOOKUP;
          end
        end
        default: state_q <= LOOKUP;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int n_tests = 0;
  int n_fail  = 0;

  icache #(.SETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .iflush   (iflush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Miss on a, hold iwait for 'waits' FILL cycles, then return d.
  task automatic fill(input logic [31:0] a, input int waits, input logic [31:0] d);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    #1;
    check("miss_ihit", {31'b0, ihit}, 32'h0);
    tick();
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        iwait = 1'b0;
        iload = d;
      end
      #1;
      check("fill_iren", {31'b0, iREN}, 32'h1);
      check("fill_iaddr", iaddr, {a[31:2], 2'b00});
      check("fill_ihit", {31'b0, ihit}, 32'h0);
      tick();
    end
    iwait = 1'b1;
    iload = 32'h0;
    #1;
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] a, input logic [31:0] d);
    imemREN  = 1'b1;
    imemaddr = a;
    #1;
    check({tag, "_ihit"}, {31'b0, ihit}, 32'h1);
    check({tag, "_load"}, imemload, d);
    check({tag, "_iren"}, {31'b0, iREN}, 32'h0);
  endtask

  task automatic expect_miss(input string tag, input logic [31:0] a);
    imemREN  = 1'b1;
    imemaddr = a;
    #1;
    check({tag, "_ihit"}, {31'b0, ihit}, 32'h0);
    check({tag, "_load"}, imemload, 32'h0);
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iflush   = 1'b0;
    iwait    = 1'b1;
    iload    = 32'h0;
    repeat (2) @(posedge CLK);
    #2;
    check("rst_ihit", {31'b0, ihit}, 32'h0);
    check("rst_load", imemload, 32'h0);
    check("rst_iren", {31'b0, iREN}, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    nRST = 1'b1;
    tick();

    // cold miss, 3 wait cycles
    fill(32'h0000_0040, 3, 32'h2001_0005);
    expect_hit("cold", 32'h0000_0040, 32'h2001_0005);
    tick();
    expect_hit("repeat", 32'h0000_0040, 32'h2001_0005);
    tick();
    check("repeat_iren_next", {31'b0, iREN}, 32'h0);

    // conflict eviction on idx 0; byte offset ignored
    fill(32'h0000_0080, 0, 32'hDEAD_BEEF);
    expect_hit("evict_new", 32'h0000_0083, 32'hDEAD_BEEF);
    expect_miss("evict_old", 32'h0000_0040);
    tick();
    check("evict_refill_iren", {31'b0, iREN}, 32'h1);
    check("evict_refill_iaddr", iaddr, 32'h0000_0040);
    iwait = 1'b0;
    iload = 32'h2001_0005;
    tick();
    iwait = 1'b1;
    expect_hit("evict_back", 32'h0000_0040, 32'h2001_0005);
    expect_miss("evict_gone", 32'h0000_0080);
    imemREN = 1'b0;
    tick();

    // address change and request drop during fill
    expect_miss("chg_miss", 32'h0000_0044);
    tick();
    imemaddr = 32'h0000_0100;
    imemREN  = 1'b0;
    #1;
    check("chg_iaddr0", iaddr, 32'h0000_0044);
    check("chg_ihit0", {31'b0, ihit}, 32'h0);
    tick();
    check("chg_iaddr1", iaddr, 32'h0000_0044);
    check("chg_iren1", {31'b0, iREN}, 32'h1);
    iwait = 1'b0;
    iload = 32'h1111_2222;
    tick();
    iwait = 1'b1;
    #1;
    check("chg_done_iren", {31'b0, iREN}, 32'h0);
    check("chg_done_ihit", {31'b0, ihit}, 32'h0);
    expect_hit("chg_later", 32'h0000_0044, 32'h1111_2222);
    expect_hit("chg_other", 32'h0000_0040, 32'h2001_0005);

    // flush invalidates everything
    imemREN = 1'b0;
    iflush  = 1'b1;
    tick();
    iflush = 1'b0;
    expect_miss("flush_40", 32'h0000_0040);
    expect_miss("flush_44", 32'h0000_0044);
    tick();
    check("flush_fill_iren", {31'b0, iREN}, 32'h1);
    // flush coincides with fill completion
    iwait  = 1'b0;
    iload  = 32'h5555_AAAA;
    iflush = 1'b1;
    imemREN = 1'b0;
    tick();
    iflush = 1'b0;
    iwait  = 1'b1;
    #1;
    check("flushwin_iren", {31'b0, iREN}, 32'h0);
    expect_miss("flushwin_44", 32'h0000_0044);
    imemREN = 1'b0;

    // flush mid-fill abandons it
    expect_miss("abort_48", 32'h0000_0048);
    tick();
    check("abort_iren_before", {31'b0, iREN}, 32'h1);
    imemREN = 1'b0;
    iflush  = 1'b1;
    tick();
    iflush = 1'b0;
    #1;
    check("abort_iren_after", {31'b0, iREN}, 32'h0);
    check("abort_iaddr_after", iaddr, 32'h0);

    // reset mid-fill
    fill(32'h0000_004C, 1, 32'h0BAD_F00D);
    expect_hit("pre_rst", 32'h0000_004C, 32'h0BAD_F00D);
    expect_miss("rst_req", 32'h0000_0040);
    tick();
    check("rst_fill_iren", {31'b0, iREN}, 32'h1);
    iwait = 1'b0;
    iload = 32'h7777_7777;
    #1;
    nRST = 1'b0;
    #1;
    check("rstmid_iren", {31'b0, iREN}, 32'h0);
    check("rstmid_iaddr", iaddr, 32'h0);
    check("rstmid_ihit", {31'b0, ihit}, 32'h0);
    check("rstmid_load", imemload, 32'h0);
    tick();
    nRST  = 1'b1;
    iwait = 1'b1;
    expect_miss("post_rst_40", 32'h0000_0040);
    expect_miss("post_rst_4c", 32'h0000_004C);
    imemREN = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-block instruction cache between the datapath fetch stage and the memory controller's instruction port. Hits return the instruction combinationally in the request cycle. A miss runs a small fill FSM that drives iREN/iaddr to the memory controller, waits out iwait, and writes the returned word into the indexed frame. The memory controller gives data-side traffic priority, so arbitrarily long iwait stalls are normal operation.

## Interface
- SETS, 16, number of frames; power of two ≥ 2; index width IDX_W = log2(SETS)
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  datapath instruction read request
- imemaddr  in  32  datapath byte address (word aligned; bits [1:0] ignored)
- iflush  in  1  synchronous invalidate-all
- ihit  out  1  requested word valid on imemload this cycle
- imemload  out  32  instruction word on hit, else 0
- iREN  out  1  read request to memory controller
- iaddr  out  32  word address to memory controller, bits [1:0] = 0
- iwait  in  1  memory controller busy; data not yet valid
- iload  in  32  word from memory controller, valid when iREN & !iwait

## Operation
- Address split: tag = addr[31:IDX_W+2], idx = addr[IDX_W+1:2], byte offset [1:0] ignored.
- Per frame: valid bit, tag, 32-bit data.
- Two-state FSM:
  - LOOKUP (reset state)
  - FILL
- LOOKUP:
  - hit = imemREN & valid[idx] & (tag == stored tag). Drive ihit = 1 and imemload = frame data.
  - On a miss with imemREN = 1: latch {imemaddr[31:2], 2'b00} into the miss address register and go to FILL.
  - iREN = 0 in this state.
- FILL:
  - Drive iREN = 1 and iaddr = the latched miss address. ihit = 0.
  - When iwait = 0: write the frame at the latched idx (valid = 1, latched tag, data = iload), then return to LOOKUP.
  - While iwait = 1: hold in FILL.
- imemREN falling during FILL does not abort the fill. The RAM transaction always completes and the frame is written.
- imemaddr changing during FILL is ignored. Only the latched address is used. Back in LOOKUP, the current imemaddr is re-checked normally.
- iflush = 1 clears every valid bit at the next edge and forces the state to LOOKUP:
  - If the flush coincides with a fill completion, the flush wins and the frame stays invalid.
  - If the flush arrives mid-FILL, the fill is abandoned: iREN drops the next cycle.
- Outputs when idle or in reset:
  - ihit = 0, imemload = 0, iREN = 0, iaddr = 0.
  - Reset clears all valid bits, tags, data, the miss address register, and sets state = LOOKUP.
- Reset mid-FILL: iREN drops asynchronously with nRST low; no frame is written.

## Timing
- Hit latency: 0 cycles. ihit and imemload are combinational from imemaddr, imemREN, and the frame contents.
- Miss on cycle 0:
  - Cycles 1..k: FILL with iREN = 1, where k is the first cycle with iwait = 0.
  - The frame is written at the end of cycle k.
  - Cycle k+1: LOOKUP hit.
- Minimum miss penalty is 2 cycles (iwait = 0 on the first FILL cycle).
- The fill write and the next lookup never occur in the same cycle, so there is no bypass path from iload to imemload.
- iaddr and iREN are stable for the whole FILL state (registered address, state-decoded iREN).

## Structure
- In cpu_types_pkg:
  - icachef_t packed struct {tag, idx, bytoff} sized for SETS = 16 (26/4/2 bits).
  - icache_frame_t struct {valid, tag, data}.
  - State enum {LOOKUP, FILL}.
- Single module. Frame array, FSM, and miss-address register are inline; no sub-module required.

## Test plan
- Cold miss: imemREN = 1, imemaddr = 0x0000_0040, iwait held 1 for 3 cycles then 0, iload = 0x2001_0005.
  - iREN = 1 with iaddr = 0x40 for 4 cycles.
  - Next cycle: ihit = 1, imemload = 0x2001_0005.
- Repeat hit: re-request 0x40 → ihit = 1 in the same cycle, iREN stays 0.
- Conflict eviction: fill 0x40 (idx 0), then request 0x80 (same idx, different tag).
  - Miss, fill with 0xDEAD_BEEF.
  - Re-request 0x40 → miss again.
- Address change and request drop mid-fill: miss on 0x44.
  - During FILL, set imemaddr = 0x100 and imemREN = 0.
  - Required: iaddr stays 0x44, frame idx 1 is filled, no ihit; a later request for 0x44 hits.
- Flush:
  - After filling 0x40 and 0x44, pulse iflush → both subsequent requests miss.
  - Flush asserted in the iwait = 0 cycle → frame stays invalid.
- Reset mid-FILL: drop nRST while iREN = 1 → iREN, ihit, imemload = 0 immediately; post-reset request to the same address misses.
